// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC sequencing and I-cache read control: next-PC select, PC stall, kill marking.
// Optional FETCH_PERF_EN adds saturating miss/redirect/kill performance counters.
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0000_2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_cur,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        icache_stall,
    output logic [31:0] pc_next,
    output logic        pc_stall,
    output logic        icache_re,
    output logic [31:0] icache_addr,
    output logic        inst_valid,
    output logic [31:0] inst_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_miss_cycles,
    output logic [31:0] perf_redirects,
    output logic [31:0] perf_kills
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StMiss, StMissKill} state_t;

    state_t      state;
    logic        pend_valid;
    logic [31:0] pend_pc;
    logic        fetch_live;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            pend_valid <= 1'b0;
            pend_pc    <= '0;
            fetch_live <= 1'b0;
            inst_pc    <= '0;
        end else begin
            // The read issued this cycle stays live only if it is a fresh, right-path address;
            // a miss exit re-reads the address that just completed.
            fetch_live <= (state == StRun) && !icache_stall && !redirect_valid;
            unique case (state)
                StIdle: begin
                    state <= StRun;
                end
                StRun, StMiss: begin
                    inst_pc <= pc_cur;
                    if (icache_stall && redirect_valid) begin
                        pend_valid <= 1'b1;
                        pend_pc    <= redirect_pc;
                        state      <= StMissKill;
                    end else if (icache_stall) begin
                        state <= StMiss;
                    end else begin
                        state <= StRun;
                    end
                end
                StMissKill: begin
                    inst_pc <= pc_cur;
                    if (icache_stall) begin
                        if (redirect_valid) begin
                            pend_pc <= redirect_pc;
                        end
                    end else begin
                        pend_valid <= 1'b0;
                        state      <= StRun;
                    end
                end
            endcase
        end
    end

    always_comb begin
        icache_addr = pc_cur;
        pc_next     = redirect_valid ? redirect_pc : (pend_valid ? pend_pc : pc_cur + 32'd4);
        icache_re   = 1'b0;
        pc_stall    = 1'b1;
        inst_valid  = 1'b0;
        if (!reset) begin
            unique case (state)
                StIdle: begin
                    icache_re = 1'b0;
                end
                StRun: begin
                    icache_re  = 1'b1;
                    pc_stall   = icache_stall | (stall_in & ~redirect_valid);
                    inst_valid = ~icache_stall & fetch_live & ~redirect_valid;
                end
                StMiss: begin
                    icache_re  = 1'b1;
                    pc_stall   = icache_stall | (stall_in & ~redirect_valid);
                    inst_valid = ~icache_stall & ~redirect_valid;
                end
                StMissKill: begin
                    icache_re = 1'b1;
                    pc_stall  = icache_stall;
                end
            endcase
        end
    end

    // The PC register is expected to hold the reset vector while we sit in IDLE.
    a_idle_pc: assert property (@(posedge clk) disable iff (reset)
        (state == StIdle) |-> (pc_cur == RESET_VEC));

`ifdef FETCH_PERF_EN
    logic in_miss;
    logic kill_evt;

    always_comb begin
        in_miss  = (state == StMiss) || (state == StMissKill);
        kill_evt = !reset && !icache_stall &&
                   (((state == StRun) && fetch_live && redirect_valid) ||
                    ((state == StMiss) && redirect_valid) ||
                    (state == StMissKill));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_miss_cycles <= '0;
            perf_redirects   <= '0;
            perf_kills       <= '0;
        end else begin
            if (in_miss && (perf_miss_cycles != 32'hFFFF_FFFF)) begin
                perf_miss_cycles <= perf_miss_cycles + 32'd1;
            end
            if (redirect_valid && (perf_redirects != 32'hFFFF_FFFF)) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
            if (kill_evt && (perf_kills != 32'hFFFF_FFFF)) begin
                perf_kills <= perf_kills + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- Sequences the fetch-stage PC register and the instruction-cache read port.
- Selects the next PC from three sources: sequential, taken branch/jump redirect, and a redirect held across a cache miss.
- Generates the PC register's stall enable.
- Marks each returned instruction valid or killed before it enters decode.

Parameters:
- RESET_VEC, 32'h0000_2000: PC value the PC register loads on reset. Used here only to check pc_cur at the IDLE exit.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pc_cur  in  32  current PC from PC register output
- stall_in  in  1  downstream hazard stall from decode/execute
- redirect_valid  in  1  taken branch/jump resolved in execute this cycle
- redirect_pc  in  32  target for redirect_valid
- icache_stall  in  1  cache busy/miss; returned data not valid this cycle
- pc_next  out  32  value PC register latches when pc_stall=0
- pc_stall  out  1  stall enable to PC register (1 = hold)
- icache_re  out  1  cache read enable
- icache_addr  out  32  cache read address
- inst_valid  out  1  cache data this cycle is a live instruction
- inst_pc  out  32  PC of instruction on cache data this cycle

Behaviour:
- Clock and reset:
  - reset: reset, synchronous, active-high. clk: clock.
  - All state updates on the posedge of clk.
- Reset values:
  - state=IDLE, inst_valid=0, inst_pc=0, pend_valid=0, pend_pc=0.
  - Outputs during reset: pc_stall=1, icache_re=0.
- Fetch timing:
  - A fetch is issued in cycle t: icache_re=1, icache_addr=pc_cur.
  - It completes in the first cycle after t with icache_stall=0.
  - In that completion cycle, inst_pc equals the issued address.
- pc_next priority, highest first: redirect_valid ? redirect_pc : pend_valid ? pend_pc : pc_cur+4. The +4 wraps modulo 2^32.
- States:
  - IDLE (first cycle after reset):
    - icache_re=0, pc_stall=1, inst_valid=0.
    - Next state RUN.
  - RUN:
    - icache_re=1.
    - pc_stall = icache_stall | (stall_in & ~redirect_valid).
    - If icache_stall=1 and redirect_valid=0: go to MISS.
    - If icache_stall=1 and redirect_valid=1: capture pend_pc<=redirect_pc, pend_valid<=1, go to MISS_KILL. pc_stall stays 1.
    - If icache_stall=0: inst_valid = issued-fetch-live & ~redirect_valid.
  - MISS:
    - icache_re=1, address held (pc_cur unchanged), pc_stall=1, inst_valid=0.
    - redirect_valid=1: capture into pend, go to MISS_KILL.
    - icache_stall falls: inst_valid=1 unless redirect_valid that cycle. pc advances per the RUN rule. Go to RUN.
  - MISS_KILL:
    - As MISS, except a newer redirect overwrites pend_pc.
    - On icache_stall=0: inst_valid=0, pc_stall=0, pc_next=pend_pc (or redirect_pc if redirect_valid). Clear pend_valid. Go to RUN.
- stall_in=1 in RUN with no miss: PC held, the same address is re-read, and inst_valid / inst_pc repeat the same instruction.
- redirect_valid and stall_in in the same cycle: redirect wins. PC loads redirect_pc and the in-flight instruction is killed.
- reset asserted in any state, including mid-miss: return to IDLE next cycle, drop pend, and force inst_valid=0.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, adds three outputs:
  - perf_miss_cycles[31:0]: cycles in MISS or MISS_KILL.
  - perf_redirects[31:0]: cycles with redirect_valid=1.
  - perf_kills[31:0]: completed fetches with inst_valid forced 0.
- Counters clear on reset and saturate at 32'hFFFF_FFFF.
- When undefined, the ports and counters are absent and all other behaviour is identical.

Test Plan:
- reset 2 cycles, release, no stalls -> IDLE one cycle, then icache_addr 0x2000, 0x2004, 0x2008 on consecutive cycles; inst_valid=1 from the second RUN cycle.
- icache_stall high 3 cycles at 0x2008 -> pc_stall=1 and addr held 0x2008 for 3 cycles; on release inst_valid=1, inst_pc=0x2008, then 0x200C.
- redirect_valid with redirect_pc=0x3000 in RUN -> instruction completing that cycle has inst_valid=0; next icache_addr=0x3000.
- redirect 0x4000 during a miss at 0x2010, then a second redirect 0x5000 still during the miss -> on release inst_valid=0 and PC loads 0x5000, not 0x4000.
- stall_in=1 for 2 cycles with simultaneous redirect 0x6000 in the second -> PC held for the first cycle, loads 0x6000 in the second.
- PC at 0xFFFF_FFFC, no redirect -> pc_next=0x0000_0000. Also, reset during MISS_KILL -> pend discarded and the next fetch is 0x2000.
